// File: rtl/cci_mpf_csr_event_counters.sv
// MPF shim event counters with a pipelined, indexed CSR read port.
//
// Seven single-cycle event wires are registered once (stage E), then each one
// increments its own N_CTR_BITS-wide counter. Counters either wrap or saturate,
// depending on SATURATE. The CSR read port has two pipeline stages:
//   cycle R   : rd_req/rd_idx sampled, counter selected and registered
//   cycle R+1 : selected value zero-extended and registered
//   cycle R+2 : rd_rsp_valid/rd_rsp_data presented for one cycle
//
// Optional feature: define MPF_CSR_EVENT_SNAPSHOT_EN to add shadow registers.
// When it is defined, snap_req copies every counter into a shadow register,
// and reads return the shadow copies. When it is not defined, snap_req is
// ignored and reads return the live counters.

module cci_mpf_csr_event_counters #(
    parameter int unsigned N_CTR_BITS = 64,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        vtp_4kb_hit,
    input  logic        vtp_4kb_miss,
    input  logic        vtp_2mb_hit,
    input  logic        vtp_2mb_miss,
    input  logic        vtp_pt_walk_busy,
    input  logic        vtp_failed_translation,
    input  logic        vc_map_mapping_changed,

    input  logic        clr_all,
    input  logic        clr_one,
    input  logic [2:0]  clr_idx,

    input  logic        rd_req,
    input  logic [2:0]  rd_idx,
    input  logic        snap_req,

    output logic        rd_rsp_valid,
    output logic [63:0] rd_rsp_data
);

    localparam int unsigned NumEvents = 7;

    typedef logic [N_CTR_BITS-1:0] ctr_t;

    // ------------------------------------------------------------------
    // Stage E: event registers
    // ------------------------------------------------------------------
    logic [NumEvents-1:0] ev_d, ev_q;

    // Gather the event wires into a vector ordered by counter index.
    always_comb begin
        ev_d = {vc_map_mapping_changed, vtp_failed_translation, vtp_pt_walk_busy,
                vtp_2mb_miss, vtp_2mb_hit, vtp_4kb_miss, vtp_4kb_hit};
    end

    // Register the events so that every counter sees a clean one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [NumEvents-1:0] clr_vec;
    ctr_t                 ctr_d [NumEvents];
    ctr_t                 ctr_q [NumEvents];

    // Decode the clears. clr_all overrides clr_one, and clr_idx 7 selects nothing.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NumEvents; i++) begin
            if (clr_all || (clr_one && (clr_idx == 3'(i)))) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // Compute each counter's next value. A clear comes before the count, so a
    // clear in the same cycle as an event leaves the counter at 1.
    always_comb begin
        for (int i = 0; i < NumEvents; i++) begin
            ctr_d[i] = ctr_q[i];
            if (clr_vec[i]) begin
                ctr_d[i] = ev_q[i] ? ctr_t'(1'b1) : '0;
            end else if (ev_q[i]) begin
                if (SATURATE && (&ctr_q[i])) begin
                    ctr_d[i] = ctr_q[i];
                end else begin
                    ctr_d[i] = ctr_q[i] + ctr_t'(1'b1);
                end
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumEvents; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumEvents; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read source: shadow copies or live counters
    // ------------------------------------------------------------------
    ctr_t rd_src [NumEvents];

`ifdef MPF_CSR_EVENT_SNAPSHOT_EN
    ctr_t shadow_d [NumEvents];
    ctr_t shadow_q [NumEvents];

    // On snap_req, copy the current counter values. Clears do not affect shadows.
    always_comb begin
        for (int i = 0; i < NumEvents; i++) begin
            shadow_d[i] = snap_req ? ctr_q[i] : shadow_q[i];
        end
    end

    // Shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumEvents; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumEvents; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Reads see the shadow copies.
    always_comb begin
        for (int i = 0; i < NumEvents; i++) begin
            rd_src[i] = shadow_q[i];
        end
    end
`else
    logic unused_snap_req;
    assign unused_snap_req = snap_req;

    // Reads see the live counters.
    always_comb begin
        for (int i = 0; i < NumEvents; i++) begin
            rd_src[i] = ctr_q[i];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    logic        rd1_v_d, rd1_v_q;
    ctr_t        rd1_data_d, rd1_data_q;
    logic        rsp_v_d, rsp_v_q;
    logic [63:0] rsp_data_d, rsp_data_q;

    // Stage 1: select the requested counter using its value from the request cycle.
    // Index 7, and any cycle with no request, produce 0.
    always_comb begin
        rd1_v_d    = rd_req;
        rd1_data_d = '0;
        for (int i = 0; i < NumEvents; i++) begin
            if (rd_req && (rd_idx == 3'(i))) begin
                rd1_data_d = rd_src[i];
            end
        end
    end

    // Stage 2: zero-extend the selected value to the 64-bit CSR width.
    always_comb begin
        rsp_v_d                     = rd1_v_q;
        rsp_data_d                  = '0;
        rsp_data_d[N_CTR_BITS-1:0]  = rd1_data_q;
    end

    // Pipeline registers. A reset drops any read that is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_v_q    <= 1'b0;
            rd1_data_q <= '0;
            rsp_v_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rd1_v_q    <= rd1_v_d;
            rd1_data_q <= rd1_data_d;
            rsp_v_q    <= rsp_v_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Drive the read response outputs.
    always_comb begin
        rd_rsp_valid = rsp_v_q;
        rd_rsp_data  = rsp_data_q;
    end

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Randomised and directed bench for cci_mpf_csr_event_counters. Three
// instances share one stimulus: 64-bit wrapping, 4-bit wrapping and
// 4-bit saturating. A counting model checks the response port every cycle.

module tb_cci_mpf_csr_event_counters;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  ev = '0;
    logic        clr_all = 1'b0;
    logic        clr_one = 1'b0;
    logic [2:0]  clr_idx = '0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_idx = '0;
    logic        snap_req = 1'b0;

    logic        d_v [3];
    logic [63:0] d_d [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cci_mpf_csr_event_counters #(.N_CTR_BITS(64), .SATURATE(1'b0)) u_dut64 (
        .clk(clk), .reset(reset),
        .vtp_4kb_hit(ev[0]), .vtp_4kb_miss(ev[1]), .vtp_2mb_hit(ev[2]),
        .vtp_2mb_miss(ev[3]), .vtp_pt_walk_busy(ev[4]),
        .vtp_failed_translation(ev[5]), .vc_map_mapping_changed(ev[6]),
        .clr_all(clr_all), .clr_one(clr_one), .clr_idx(clr_idx),
        .rd_req(rd_req), .rd_idx(rd_idx), .snap_req(snap_req),
        .rd_rsp_valid(d_v[0]), .rd_rsp_data(d_d[0])
    );

    cci_mpf_csr_event_counters #(.N_CTR_BITS(4), .SATURATE(1'b0)) u_dut4w (
        .clk(clk), .reset(reset),
        .vtp_4kb_hit(ev[0]), .vtp_4kb_miss(ev[1]), .vtp_2mb_hit(ev[2]),
        .vtp_2mb_miss(ev[3]), .vtp_pt_walk_busy(ev[4]),
        .vtp_failed_translation(ev[5]), .vc_map_mapping_changed(ev[6]),
        .clr_all(clr_all), .clr_one(clr_one), .clr_idx(clr_idx),
        .rd_req(rd_req), .rd_idx(rd_idx), .snap_req(snap_req),
        .rd_rsp_valid(d_v[1]), .rd_rsp_data(d_d[1])
    );

    cci_mpf_csr_event_counters #(.N_CTR_BITS(4), .SATURATE(1'b1)) u_dut4s (
        .clk(clk), .reset(reset),
        .vtp_4kb_hit(ev[0]), .vtp_4kb_miss(ev[1]), .vtp_2mb_hit(ev[2]),
        .vtp_2mb_miss(ev[3]), .vtp_pt_walk_busy(ev[4]),
        .vtp_failed_translation(ev[5]), .vc_map_mapping_changed(ev[6]),
        .clr_all(clr_all), .clr_one(clr_one), .clr_idx(clr_idx),
        .rd_req(rd_req), .rd_idx(rd_idx), .snap_req(snap_req),
        .rd_rsp_valid(d_v[2]), .rd_rsp_data(d_d[2])
    );

    // ---------------- behavioural model ----------------
    int                nbits [3] = '{64, 4, 4};
    bit                sat   [3] = '{1'b0, 1'b0, 1'b1};
    longint unsigned   m_cnt [3][7];
    longint unsigned   m_shadow [3][7];
    logic [6:0]        m_ev_prev;
    bit                m_p1_v, m_out_v;
    longint unsigned   m_p1_d [3];
    longint unsigned   m_out_d [3];

    function automatic longint unsigned max_of(input int n);
        if (n >= 64) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (64'd1 << n) - 64'd1;
    endfunction

    // Advance the model by one clock edge, using the inputs currently driven.
    task automatic model_update();
        longint unsigned rv [3];
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 7; i++) begin
                    m_cnt[k][i] = 0;
                    m_shadow[k][i] = 0;
                end
                m_p1_d[k] = 0;
                m_out_d[k] = 0;
            end
            m_p1_v = 0;
            m_out_v = 0;
            m_ev_prev = '0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            rv[k] = 0;
            if (rd_idx != 3'd7) begin
`ifdef MPF_CSR_EVENT_SNAPSHOT_EN
                rv[k] = m_shadow[k][rd_idx];
`else
                rv[k] = m_cnt[k][rd_idx];
`endif
            end
        end
        m_out_v = m_p1_v;
        m_p1_v  = rd_req;
        for (int k = 0; k < 3; k++) begin
            m_out_d[k] = m_p1_d[k];
            m_p1_d[k]  = rv[k];
            if (snap_req) begin
                for (int i = 0; i < 7; i++) m_shadow[k][i] = m_cnt[k][i];
            end
            for (int i = 0; i < 7; i++) begin
                longint unsigned inc;
                bit cleared;
                inc = m_ev_prev[i] ? 64'd1 : 64'd0;
                cleared = clr_all || (clr_one && (clr_idx == 3'(i)));
                if (cleared) m_cnt[k][i] = inc;
                else if (sat[k] && m_cnt[k][i] == max_of(nbits[k])) m_cnt[k][i] = m_cnt[k][i];
                else m_cnt[k][i] = (m_cnt[k][i] + inc) & max_of(nbits[k]);
            end
        end
        m_ev_prev = ev;
    endtask

    // Compare the DUT response port against the model.
    task automatic check_cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d_v[k] !== m_out_v) begin
                errors++;
                $display("FAIL valid inst%0d t=%0t got %b want %b", k, $time, d_v[k], m_out_v);
            end
            if (m_out_v) begin
                checks++;
                if (d_d[k] !== m_out_d[k]) begin
                    errors++;
                    $display("FAIL data inst%0d t=%0t got %0d want %0d", k, $time, d_d[k],
                             m_out_d[k]);
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic lit(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        ev = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Issue one read, wait for its response slot, and pin the valid flag.
    task automatic do_read(input int idx);
        rd_req = 1'b1;
        rd_idx = 3'(idx);
        step();
        rd_req = 1'b0;
        step();
        lit("read_valid", 64'(d_v[0]), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ev = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state, then back-to-back reads of all counters
        do_reset();
        lit("reset_valid", 64'(d_v[0]), 64'd0);
        lit("reset_data", d_d[0], 64'd0);
        for (int i = 0; i < 7; i++) begin
            rd_req = 1'b1;
            rd_idx = 3'(i);
            step();
        end
        rd_req = 1'b0;
        idle(2);

        // 2: 4KB hit 5 cycles, 2MB miss 3 cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ev = '0;
            ev[0] = 1'b1;
            ev[3] = (i < 3);
            step();
        end
        idle(2);
        do_read(0);
        lit("t2_idx0", d_d[0], 64'd5);
        lit("t2_idx0_4b", d_d[1], 64'd5);
        do_read(3);
        lit("t2_idx3", d_d[0], 64'd3);
        do_read(1);
        lit("t2_idx1", d_d[0], 64'd0);

        // 3: 17 failed translations -> 4-bit wrap / saturate
        do_reset();
        for (int i = 0; i < 17; i++) begin
            ev = 7'b010_0000;
            step();
        end
        idle(2);
        do_read(5);
        lit("t3_64", d_d[0], 64'd17);
        lit("t3_wrap", d_d[1], 64'd1);
        lit("t3_sat", d_d[2], 64'd15);

        // 4: clear with a coincident registered event, then clr_all with clr_one
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ev = 7'b000_0010;
            step();
        end
        idle(2);
        ev = 7'b000_0010;
        step();
        ev = '0;
        clr_one = 1'b1;
        clr_idx = 3'd1;
        rd_req = 1'b1;
        rd_idx = 3'd1;
        step();
        clr_one = 1'b0;
        rd_req = 1'b0;
        step();
        lit("t4_preclear", d_d[0], 64'd9);
        do_read(1);
        lit("t4_postclear", d_d[0], 64'd1);
        clr_all = 1'b1;
        clr_one = 1'b1;
        clr_idx = 3'd2;
        step();
        clr_all = 1'b0;
        clr_one = 1'b0;
        do_read(1);
        lit("t4_clrall_idx1", d_d[0], 64'd0);

        // 5: index 7 reads zero; a reset during a read drops the response
        do_read(7);
        lit("t5_idx7", d_d[0], 64'd0);
        rd_req = 1'b1;
        rd_idx = 3'd1;
        step();
        rd_req = 1'b0;
        reset = 1'b1;
        step();
        lit("t5_reset_drop", 64'(d_v[0]), 64'd0);
        reset = 1'b0;
        step();
        lit("t5_reset_drop2", 64'(d_v[0]), 64'd0);

        // 6: snapshot sequence
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ev = 7'b001_0000;
            step();
        end
        idle(2);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev = 7'b001_0000;
            step();
        end
        idle(2);
        do_read(4);
`ifdef MPF_CSR_EVENT_SNAPSHOT_EN
        lit("t6_snap_first", d_d[0], 64'd10);
`else
        lit("t6_snap_first", d_d[0], 64'd14);
`endif
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        do_read(4);
        lit("t6_snap_second", d_d[0], 64'd14);

        // Random phase checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            ev       = 7'($urandom());
            clr_all  = ($urandom_range(0, 63) == 0);
            clr_one  = ($urandom_range(0, 15) == 0);
            clr_idx  = 3'($urandom_range(0, 7));
            rd_req   = $urandom_range(0, 1) == 1;
            rd_idx   = 3'($urandom_range(0, 7));
            snap_req = ($urandom_range(0, 31) == 0);
            step();
        end
        reset = 1'b0;
        clr_all = 1'b0;
        clr_one = 1'b0;
        rd_req = 1'b0;
        snap_req = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
